// File: rtl/uart_pkg.sv
// Shared state type and default sizing for the UART receive controller.
package uart_pkg;
   typedef enum logic [1:0] {OFF = 2'd0, ARM = 2'd1, RUN = 2'd2} rx_ctrl_state_t;

   localparam int OVERSAMPLE_RATE = 16;
   localparam int FIFO_DEPTH      = 4;
   localparam int BREAK_TICKS     = 160;
endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Downstream received-byte stream (first-word-fall-through valid/ready).
interface uart_rx_ctrl_if;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;

   modport master (output m_data, output m_valid, input m_ready);
   modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Power-of-two receive FIFO; head entry is always visible on dout.
module uart_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 8
) (
   input  logic                   uart_clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [DW-1:0]          din,
   output logic [DW-1:0]          dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DEPTH-1:0][DW-1:0] mem;
   logic [AW-1:0]            wr_ptr, rd_ptr;
   logic                     do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge uart_clk or negedge rst_n) begin
      if (!rst_n) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
      end
   end
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: sample-tick generation, line arming, byte capture
// into a FIFO, and sticky/level line status.
module uart_rx_ctrl #(
   parameter int FIFO_DEPTH      = uart_pkg::FIFO_DEPTH,
   parameter int OVERSAMPLE_RATE = uart_pkg::OVERSAMPLE_RATE,
   parameter int BREAK_TICKS     = uart_pkg::BREAK_TICKS
) (
   input  logic                        uart_clk,
   input  logic                        rst_n,
   input  logic                        cfg_enable,
   input  logic [15:0]                 cfg_divisor,
   input  logic                        rx_pin,
   output logic                        sample_tick,
   output logic                        rx_serial_sync,
   input  logic [7:0]                  core_data,
   input  logic                        core_valid,
   input  logic                        core_frame_error,
   output logic                        core_ready,
   uart_rx_ctrl_if.master              m_if,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   input  logic                        clr_status,
   output logic                        overrun,
   output logic                        frame_err,
   output logic                        break_detect
);
   import uart_pkg::*;

   localparam int ARM_W = $clog2(OVERSAMPLE_RATE + 1);
   localparam int BRK_W = $clog2(BREAK_TICKS + 1);

   rx_ctrl_state_t   state, state_nxt;
   logic [1:0]       sync_q;
   logic             line;
   logic [15:0]      div_cnt, div_max;
   logic [ARM_W-1:0] arm_cnt;
   logic [BRK_W-1:0] brk_cnt;
   logic             core_valid_q, core_fe_q;
   logic             push, pop, fifo_full, fifo_empty, ovr_evt, fe_evt;

   assign line           = sync_q[1];
   assign core_ready     = 1'b1;
   assign div_max        = (cfg_divisor < 16'd2) ? 16'd1 : cfg_divisor;
   assign rx_serial_sync = (state == RUN) ? line : 1'b1;
   assign break_detect   = (brk_cnt == BRK_W'(BREAK_TICKS));

   always_ff @(posedge uart_clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b11;
      else        sync_q <= {sync_q[0], rx_pin};
   end

   // ">=" lets a divisor shrunk below the running count wrap immediately.
   always_ff @(posedge uart_clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt     <= '0;
         sample_tick <= 1'b0;
      end else if (state == OFF || !cfg_enable) begin
         div_cnt     <= '0;
         sample_tick <= 1'b0;
      end else if (div_cnt >= div_max - 16'd1) begin
         div_cnt     <= '0;
         sample_tick <= 1'b1;
      end else begin
         div_cnt     <= div_cnt + 16'd1;
         sample_tick <= 1'b0;
      end
   end

   always_ff @(posedge uart_clk or negedge rst_n) begin
      if (!rst_n) state <= OFF;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         OFF:     if (cfg_enable) state_nxt = ARM;
         ARM:     if (sample_tick && line && arm_cnt == ARM_W'(OVERSAMPLE_RATE - 1))
                     state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = OFF;
      endcase
      if (!cfg_enable) state_nxt = OFF;
   end

   always_ff @(posedge uart_clk or negedge rst_n) begin
      if (!rst_n)             arm_cnt <= '0;
      else if (state != ARM)  arm_cnt <= '0;
      else if (sample_tick)   arm_cnt <= line ? arm_cnt + ARM_W'(1) : '0;
   end

   always_ff @(posedge uart_clk or negedge rst_n) begin
      if (!rst_n)                                 brk_cnt <= '0;
      else if (state != RUN)                      brk_cnt <= '0;
      else if (sample_tick && line)               brk_cnt <= '0;
      else if (sample_tick && !break_detect)      brk_cnt <= brk_cnt + BRK_W'(1);
   end

   always_ff @(posedge uart_clk or negedge rst_n) begin
      if (!rst_n) begin
         core_valid_q <= 1'b0;
         core_fe_q    <= 1'b0;
      end else begin
         core_valid_q <= core_valid;
         core_fe_q    <= core_frame_error;
      end
   end

   assign push    = core_valid && !core_valid_q && (state == RUN);
   assign pop     = m_if.m_valid && m_if.m_ready;
   assign ovr_evt = push && fifo_full && !pop;
   assign fe_evt  = core_frame_error && !core_fe_q && (state == RUN);

   // Sticky status: a new event outranks a clear in the same cycle.
   always_ff @(posedge uart_clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (ovr_evt)         overrun <= 1'b1;
         else if (clr_status) overrun <= 1'b0;
         if (fe_evt)          frame_err <= 1'b1;
         else if (clr_status) frame_err <= 1'b0;
      end
   end

   assign m_if.m_valid = !fifo_empty;

   uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .DW(8)) u_fifo (
      .uart_clk (uart_clk),
      .rst_n    (rst_n),
      .push     (push),
      .pop      (pop),
      .din      (core_data),
      .dout     (m_if.m_data),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: stimulus predicts accepted bytes into a
// queue, a negedge monitor pops and compares every byte the DUT hands over.
module tb_uart_rx_ctrl;
   import uart_pkg::*;

   localparam int DEPTH = 4;
   localparam int OSR   = 16;
   localparam int BRK   = 160;

   logic        uart_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_enable = 1'b0;
   logic [15:0] cfg_divisor = 16'd4;
   logic        rx_pin = 1'b1;
   logic [7:0]  core_data = 8'h00;
   logic        core_valid = 1'b0;
   logic        core_frame_error = 1'b0;
   logic        clr_status = 1'b0;
   logic        sample_tick, rx_serial_sync, core_ready;
   logic        overrun, frame_err, break_detect;
   logic [$clog2(DEPTH):0] fifo_count;

   uart_rx_ctrl_if m_if ();

   uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE_RATE(OSR), .BREAK_TICKS(BRK)) dut (
      .uart_clk         (uart_clk),
      .rst_n            (rst_n),
      .cfg_enable       (cfg_enable),
      .cfg_divisor      (cfg_divisor),
      .rx_pin           (rx_pin),
      .sample_tick      (sample_tick),
      .rx_serial_sync   (rx_serial_sync),
      .core_data        (core_data),
      .core_valid       (core_valid),
      .core_frame_error (core_frame_error),
      .core_ready       (core_ready),
      .m_if             (m_if),
      .fifo_count       (fifo_count),
      .clr_status       (clr_status),
      .overrun          (overrun),
      .frame_err        (frame_err),
      .break_detect     (break_detect)
   );

   always #5 uart_clk = ~uart_clk;

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   logic [7:0] exp_q[$];
   bit         exp_ovr = 1'b0;
   bit         exp_fe = 1'b0;
   bit         in_run = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial forever @(posedge uart_clk) cyc++;

   // Byte monitor: a pop happens at the next posedge whenever valid&&ready here.
   initial forever begin
      @(negedge uart_clk);
      if (rst_n && m_if.m_valid && m_if.m_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte: got %02h required no byte", m_if.m_data);
         end else begin
            chk("m_data", 32'(m_if.m_data), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge uart_clk);
         #1;
      end
   endtask

   task automatic wait_tick();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge uart_clk);
         if (sample_tick) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL tick_timeout: got no sample_tick in 100 cycles, required one");
      end
   endtask

   // Reference: a byte is taken only in RUN, and only if a slot is free or
   // a pop of a non-empty FIFO happens in the same cycle.
   task automatic send_byte(input logic [7:0] b, input bit rdy);
      core_data    = b;
      core_valid   = 1'b1;
      m_if.m_ready = rdy;
      if (in_run) begin
         if (exp_q.size() < DEPTH || (rdy && exp_q.size() > 0)) exp_q.push_back(b);
         else exp_ovr = 1'b1;
      end
      step(1);
      core_valid = 1'b0;
      step(1);
   endtask

   task automatic drain();
      m_if.m_ready = 1'b1;
      for (int i = 0; i < 64 && (exp_q.size() != 0 || m_if.m_valid); i++) step(1);
      chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("drain_fifo_count", 32'(fifo_count), 32'd0);
      m_if.m_ready = 1'b0;
   endtask

   task automatic clear_status();
      clr_status = 1'b1;
      step(1);
      clr_status = 1'b0;
      exp_ovr = 1'b0;
      exp_fe  = 1'b0;
   endtask

   task automatic tick_gaps(input int d, input int n);
      int t0;
      wait_tick();
      t0 = cyc;
      repeat (n) begin
         wait_tick();
         chk("tick_gap", 32'(cyc - t0), 32'(d));
         t0 = cyc;
      end
   endtask

   // Model: RUN follows the tick on which OSR consecutive high samples are seen.
   task automatic arm(input int low_start, input int low_len);
      int hi, n;
      bit done;
      hi = 0; n = 0; done = 1'b0;
      cfg_divisor = 16'd4;
      rx_pin      = 1'b1;
      cfg_enable  = 1'b1;
      while (!done && n < 80) begin
         wait_tick();
         n++;
         chk("arm_sync_gated", 32'(rx_serial_sync), 32'd1);
         hi = rx_pin ? hi + 1 : 0;
         chk("arm_not_early", 32'(dut.state == RUN), 32'd0);
         if (hi == OSR) begin
            @(negedge uart_clk);
            chk("arm_to_run", 32'(dut.state == RUN), 32'd1);
            done = 1'b1;
         end
         @(posedge uart_clk);
         #1;
         rx_pin = (n + 1 >= low_start && n + 1 < low_start + low_len) ? 1'b0 : 1'b1;
      end
      chk("arm_reached_run", 32'(done), 32'd1);
      in_run = done;
   endtask

   initial begin
      int t, cnt, lc;
      m_if.m_ready = 1'b0;

      // Reset values
      #2;
      chk("rst_sample_tick", 32'(sample_tick), 32'd0);
      chk("rst_rx_serial_sync", 32'(rx_serial_sync), 32'd1);
      chk("rst_m_valid", 32'(m_if.m_valid), 32'd0);
      chk("rst_m_data", 32'(m_if.m_data), 32'd0);
      chk("rst_fifo_count", 32'(fifo_count), 32'd0);
      chk("rst_status", 32'({overrun, frame_err, break_detect}), 32'd0);
      chk("core_ready", 32'(core_ready), 32'd1);
      step(2);
      rst_n = 1'b1;
      step(2);

      // Tick spacing for several divisors, then a divisor shrunk mid-count
      cfg_divisor = 16'd4;
      cfg_enable  = 1'b1;
      tick_gaps(4, 4);
      @(posedge uart_clk); #1; cfg_divisor = 16'd0;
      tick_gaps(1, 4);
      @(posedge uart_clk); #1; cfg_divisor = 16'd1;
      tick_gaps(1, 3);
      @(posedge uart_clk); #1; cfg_divisor = 16'd6;
      tick_gaps(6, 3);
      t = cyc;
      repeat (4) @(posedge uart_clk);
      #1;
      cfg_divisor = 16'd2;
      wait_tick();
      chk("tick_after_shrink", 32'(cyc - t), 32'd5);
      tick_gaps(2, 3);
      @(posedge uart_clk); #1; cfg_enable = 1'b0;
      step(1);
      chk("off_state", 32'(dut.state == OFF), 32'd1);
      cnt = 0;
      repeat (20) begin
         @(negedge uart_clk);
         if (sample_tick) cnt++;
      end
      chk("off_no_ticks", 32'(cnt), 32'd0);
      step(1);

      // Capture is ignored while OFF
      in_run = 1'b0;
      send_byte(8'hC3, 1'b0);
      chk("off_no_capture", 32'(fifo_count), 32'd0);

      // Arm with a low glitch on ticks 10..12
      arm(10, 3);

      // Directed pair then a randomized stream with random back-pressure
      send_byte(8'h55, 1'b1);
      send_byte(8'hA3, 1'b1);
      drain();
      for (int i = 0; i < 30; i++) send_byte(8'($urandom), $urandom_range(0, 1) == 1);
      chk("overrun_random", 32'(overrun), 32'(exp_ovr));
      drain();
      clear_status();
      chk("overrun_cleared", 32'(overrun), 32'd0);

      // Overflow with no drain
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
      chk("full_count", 32'(fifo_count), 32'(exp_q.size()));
      chk("overrun_set", 32'(overrun), 32'(exp_ovr));
      drain();
      clear_status();
      chk("overrun_clr", 32'(overrun), 32'd0);

      // Push and pop together on a full FIFO
      for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 1'b0);
      send_byte(8'($urandom), 1'b1);
      chk("full_pushpop_no_ovr", 32'(overrun), 32'(exp_ovr));
      drain();

      // Frame error: sticky, set wins over clear, clear alone clears
      core_frame_error = 1'b1; step(1); core_frame_error = 1'b0; step(1);
      exp_fe = 1'b1;
      chk("frame_err_set", 32'(frame_err), 32'(exp_fe));
      core_frame_error = 1'b1; clr_status = 1'b1; step(1);
      core_frame_error = 1'b0; clr_status = 1'b0; step(1);
      chk("frame_err_set_wins", 32'(frame_err), 32'd1);
      clear_status();
      chk("frame_err_clr", 32'(frame_err), 32'(exp_fe));

      // Break: level asserted once BRK consecutive low ticks have been seen
      wait_tick();
      @(posedge uart_clk); #1; rx_pin = 1'b0;
      lc = 0;
      while (lc < BRK + 3) begin
         wait_tick();
         lc++;
         @(negedge uart_clk);
         chk("break_level", 32'(break_detect), 32'(lc >= BRK));
      end
      chk("run_sync_follows_low", 32'(rx_serial_sync), 32'd0);
      @(posedge uart_clk); #1; rx_pin = 1'b1;
      wait_tick();
      @(negedge uart_clk);
      chk("break_clear_on_high", 32'(break_detect), 32'd0);
      step(1);

      // Leaving RUN keeps queued bytes drainable and stops capture
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
      cfg_enable = 1'b0;
      step(2);
      in_run = 1'b0;
      send_byte(8'hEE, 1'b0);
      chk("off_keeps_fifo", 32'(fifo_count), 32'(exp_q.size()));
      drain();

      // Reset with bytes queued
      arm(100, 0);
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
      chk("pre_reset_count", 32'(fifo_count), 32'd3);
      rst_n = 1'b0;
      #1;
      chk("reset_m_valid", 32'(m_if.m_valid), 32'd0);
      chk("reset_fifo_count", 32'(fifo_count), 32'd0);
      chk("reset_state_off", 32'(dut.state == OFF), 32'd1);
      exp_q.delete();
      in_run     = 1'b0;
      exp_ovr    = 1'b0;
      cfg_enable = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(3);
      chk("post_reset_m_valid", 32'(m_if.m_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got no completion, required finish within time limit");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter OVERSAMPLE_RATE, default 16, sample ticks per bit.
REQ-003 SHALL have parameter BREAK_TICKS, default 160, consecutive low samples that declare a break.
REQ-004 uart_clk  in  1  sole clock, all flops posedge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 cfg_enable  in  1  receiver enable.
REQ-007 cfg_divisor  in  16  uart_clk cycles per sample tick; 0 and 1 both mean every cycle.
REQ-008 rx_pin  in  1  raw asynchronous serial line.
REQ-009 sample_tick  out  1  one-cycle tick to RX core.
REQ-010 rx_serial_sync  out  1  gated, synchronized line to RX core.
REQ-011 core_data  in  8; core_valid  in  1; core_frame_error  in  1  from RX core.
REQ-012 core_ready  out  1  to RX core, tied 1.
REQ-013 m_data  out  8; m_valid  out  1; m_ready  in  1  downstream byte stream.
REQ-014 fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries.
REQ-015 overrun, frame_err, break_detect  out  1 each  status; clr_status  in  1  clears sticky bits.

Function
REQ-016 Tick generator: counter 0..max(cfg_divisor,1)-1; sample_tick registered, high one cycle when counter wraps; counter held 0, no ticks, while state OFF.
REQ-017 Divisor reduced below current count: counter wraps on next cycle with a tick.
REQ-018 rx_pin passes a 2-flop synchronizer (reset value 1) every cycle regardless of state.
REQ-019 State machine OFF/ARM/RUN: OFF->ARM when cfg_enable=1; ARM->RUN after OVERSAMPLE_RATE consecutive ticks with synchronized line high; any low tick in ARM restarts count; any state->OFF in the cycle after cfg_enable=0.
REQ-020 rx_serial_sync = synchronized line in RUN, constant 1 in OFF and ARM.
REQ-021 Capture: push core_data into FIFO on rising edge of core_valid (registered compare), only in RUN.
REQ-022 FIFO first-word-fall-through: m_valid = (count!=0), m_data = head entry; pop when m_valid&&m_ready.
REQ-023 Push when full without pop: byte dropped, contents unchanged, overrun set.
REQ-024 Push and pop same cycle when full: both performed, count unchanged, no overrun.
REQ-025 Push and pop same cycle when empty: push only (m_valid was 0).
REQ-026 Pointers wrap modulo FIFO_DEPTH; count saturates neither way by construction.
REQ-027 frame_err set on rising edge of core_frame_error in RUN.
REQ-028 Break: counter of consecutive low ticks in RUN, saturating at BREAK_TICKS; break_detect=1 while counter==BREAK_TICKS; cleared on first high tick; break_detect also sets overrun? no -- independent, not sticky.
REQ-029 clr_status clears overrun and frame_err; a set event in the same cycle wins.
REQ-030 Entering OFF retains FIFO contents; drain via m_ready continues in all states.

Reset
REQ-031 Reset: state OFF, counters 0, synchronizer 1, FIFO empty, sample_tick 0, rx_serial_sync 1, m_valid 0, m_data 0, fifo_count 0, overrun 0, frame_err 0, break_detect 0.
REQ-032 Reset asserted mid-frame or mid-drain aborts immediately; FIFO contents discarded.

Structure
REQ-033 Package uart_pkg holds rx_ctrl_state_t (OFF, ARM, RUN) and default constants OVERSAMPLE_RATE, FIFO_DEPTH, BREAK_TICKS.
REQ-034 FIFO SHALL be sub-module uart_rx_fifo (push/pop/full/empty/count, same clock and reset).

Verification
REQ-035 cfg_divisor=4, enable: sample_tick every 4th cycle; change to 2 at count 3: tick next cycle, then every 2.
REQ-036 Enable with line high: RUN exactly 16 ticks later; line low at tick 10: RUN 16 ticks after line returns high.
REQ-037 Core valid rising edges with 0x55,0xA3 and m_ready=1: m_data 0x55 then 0xA3, one each, fifo_count back to 0.
REQ-038 m_ready=0, five bytes 0x01..0x05: fifo_count=4, overrun=1, drain yields 0x01..0x04; clr_status clears overrun.
REQ-039 Line low 160 ticks in RUN: break_detect rises on tick 160, falls on first high tick; frame_err edge sets sticky.
REQ-040 Reset asserted with 3 bytes queued: m_valid=0, fifo_count=0, state OFF same cycle.
